ar_reg: RTL and testbench
=========================

Name: ar_reg

Overview:
- 16-bit address register (AR) of the CPU datapath.
- Loads a word from the internal W bus, increments by one (instruction/argument fetch), or decrements by four (stack/frame adjustment).
- Operations are triggered by control strobes from the control unit. Each strobe assertion is edge-detected against the system clock, so one pulse produces exactly one operation.

Parameters:
- WIDTH, 16, register and bus width in bits. All arithmetic is modulo 2^WIDTH.

Ports:
- clk: input, 1, system clock. All state changes on its rising edge.
- reset: input, 1. One clock; reset is synchronous and active-high.
- w: input, WIDTH, W bus data. Loaded into AR on a load strobe.
- l_: input, 1, load strobe, active-low.
- p1: input, 1, increment-by-1 strobe, active-high.
- m4_: input, 1, decrement-by-4 strobe, active-low.
- ar: output, WIDTH, current register contents, driven directly from the register.

Behaviour:
- Strobes are synchronous to clk; no internal synchronizers. Each strobe must be held at its asserted level for at least one clk rising edge.
- Edge detection: each strobe has a one-bit history register holding its value from the previous rising edge.
  - Load event: l_ sampled 0 while history is 1.
  - Increment event: p1 sampled 1 while history is 0.
  - Decrement event: m4_ sampled 0 while history is 1.
- A strobe held asserted for many cycles produces exactly one event. Deassertion produces no event.
- Latency: on the rising edge where an event is detected, ar takes its new value, visible immediately after that edge. Zero extra pipeline cycles.
- Operations:
  - Load: ar <= w (w sampled on that edge).
  - Increment: ar <= ar + 1.
  - Decrement: ar <= ar - 4.
- Simultaneous events on the same edge:
  - Load has priority; any increment or decrement on that edge is discarded.
  - Increment and decrement together, without load: ar <= ar - 3.
- Wrap-around:
  - 0xFFFF +1 -> 0x0000.
  - 0x0002 -4 -> 0xFFFE.
  - 0x0001 -3 -> 0xFFFE.
  - No carry/borrow output.
- Reset (synchronous, active-high):
  - ar <= 0.
  - History registers <= inactive levels (l_ hist = 1, p1 hist = 0, m4_ hist = 1).
  - No operation is performed while reset is high; reset overrides all events on that edge.
- After reset release, a strobe already asserted on the first edge counts as a new assertion and produces one event.
- Reset asserted mid-pulse: the pulse is lost. If it is still asserted after release, it produces one event on the first non-reset edge.
- No events: ar holds its value indefinitely.

Test Plan:
- Reset: hold reset 2 cycles with strobes inactive -> ar = 0x0000; strobes asserted during reset have no effect.
- Load, then +1, then -4: w=0xBEEF, pulse l_ low 1 cycle -> ar=0xBEEF; pulse p1 high 1 cycle -> 0xBEF0; pulse m4_ low 1 cycle -> 0xBEEC.
- Long strobes: hold p1 high 5 cycles from ar=0x0010 -> ar=0x0011 (single event); hold m4_ low 5 cycles -> 0x000D.
- Wrap-around:
  - Load 0xFFFF, +1 -> 0x0000.
  - Load 0x0002, -4 -> 0xFFFE.
- Simultaneous events:
  - From ar=0x1000, assert p1 and m4_ on the same edge -> 0x0FFD.
  - Assert l_ with w=0x1234 together with p1 and m4_ -> 0x1234.
- Reset interaction:
  - Assert reset while p1 is held high, then release with p1 still high -> ar=0x0000 during reset, then 0x0001 on the first edge after release.
  - A later rising edge of p1 is needed for the next increment.

Source files
------------

// File: rtl/ar_reg.sv
// Address register (AR): loads from the W bus, increments by one or decrements by four.
// Each control strobe is edge-detected so one pulse yields exactly one operation.
module ar_reg #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] w,
  input  logic             l_,
  input  logic             p1,
  input  logic             m4_,
  output logic [WIDTH-1:0] ar
);

  logic             l_hist;
  logic             p1_hist;
  logic             m4_hist;
  logic             ld_ev;
  logic             inc_ev;
  logic             dec_ev;
  logic [WIDTH-1:0] ar_next;

  assign ld_ev  = ~l_  &  l_hist;
  assign inc_ev =  p1  & ~p1_hist;
  assign dec_ev = ~m4_ &  m4_hist;

  // Load wins outright; +1 and -4 on the same edge combine into -3.
  always_comb begin
    ar_next = ar;
    if (ld_ev) begin
      ar_next = w;
    end else begin
      unique case ({inc_ev, dec_ev})
        2'b10:   ar_next = ar + WIDTH'(1);
        2'b01:   ar_next = ar - WIDTH'(4);
        2'b11:   ar_next = ar - WIDTH'(3);
        default: ar_next = ar;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ar      <= '0;
      l_hist  <= 1'b1;
      p1_hist <= 1'b0;
      m4_hist <= 1'b1;
    end else begin
      ar      <= ar_next;
      l_hist  <= l_;
      p1_hist <= p1;
      m4_hist <= m4_;
    end
  end

endmodule

// File: tb/tb_ar_reg.sv
// Directed self-checking bench for ar_reg: reset, load/inc/dec, long strobes,
// wrap-around, simultaneous strobes and reset interaction.
module tb_ar_reg;

  logic        clk;
  logic        reset;
  logic [15:0] w;
  logic        l_;
  logic        p1;
  logic        m4_;
  logic [15:0] ar;

  int passed = 0;
  int total  = 0;

  ar_reg #(.WIDTH(16)) dut (
    .clk  (clk),
    .reset(reset),
    .w    (w),
    .l_   (l_),
    .p1   (p1),
    .m4_  (m4_),
    .ar   (ar)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge; inputs change and outputs are sampled 1 ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_load(input logic [15:0] val);
    w  = val;
    l_ = 1'b0;
    tick();
    l_ = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; w = 16'h0000; l_ = 1'b1; p1 = 1'b0; m4_ = 1'b1;
    tick();
    tick();
    total++;
    if (ar !== 16'h0000) $display("FAIL reset_value: ar=%h expected %h", ar, 16'h0000);
    else passed++;
    w = 16'h5555; l_ = 1'b0; p1 = 1'b1; m4_ = 1'b0;
    tick();
    total++;
    if (ar !== 16'h0000) $display("FAIL reset_blocks_strobes: ar=%h expected %h", ar, 16'h0000);
    else passed++;
    l_ = 1'b1; p1 = 1'b0; m4_ = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    total++;
    if (ar !== 16'h0000) $display("FAIL reset_release_idle: ar=%h expected %h", ar, 16'h0000);
    else passed++;
  endtask

  task automatic test_load_inc_dec();
    w = 16'hBEEF; l_ = 1'b0;
    tick();
    total++;
    if (ar !== 16'hBEEF) $display("FAIL load: ar=%h expected %h", ar, 16'hBEEF);
    else passed++;
    l_ = 1'b1; w = 16'h0000;
    tick();
    total++;
    if (ar !== 16'hBEEF) $display("FAIL load_release: ar=%h expected %h", ar, 16'hBEEF);
    else passed++;
    p1 = 1'b1;
    tick();
    total++;
    if (ar !== 16'hBEF0) $display("FAIL inc: ar=%h expected %h", ar, 16'hBEF0);
    else passed++;
    p1 = 1'b0;
    tick();
    m4_ = 1'b0;
    tick();
    total++;
    if (ar !== 16'hBEEC) $display("FAIL dec: ar=%h expected %h", ar, 16'hBEEC);
    else passed++;
    m4_ = 1'b1;
    tick();
    tick();
    total++;
    if (ar !== 16'hBEEC) $display("FAIL hold_idle: ar=%h expected %h", ar, 16'hBEEC);
    else passed++;
  endtask

  task automatic test_long_strobes();
    pulse_load(16'h0010);
    p1 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if (ar !== 16'h0011) $display("FAIL long_inc cycle %0d: ar=%h expected %h", i, ar, 16'h0011);
      else passed++;
    end
    p1 = 1'b0;
    tick();
    m4_ = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if (ar !== 16'h000D) $display("FAIL long_dec cycle %0d: ar=%h expected %h", i, ar, 16'h000D);
      else passed++;
    end
    m4_ = 1'b1;
    tick();
    total++;
    if (ar !== 16'h000D) $display("FAIL long_dec_release: ar=%h expected %h", ar, 16'h000D);
    else passed++;
  endtask

  task automatic test_wrap();
    pulse_load(16'hFFFF);
    p1 = 1'b1;
    tick();
    total++;
    if (ar !== 16'h0000) $display("FAIL wrap_inc: ar=%h expected %h", ar, 16'h0000);
    else passed++;
    p1 = 1'b0;
    tick();
    pulse_load(16'h0002);
    m4_ = 1'b0;
    tick();
    total++;
    if (ar !== 16'hFFFE) $display("FAIL wrap_dec: ar=%h expected %h", ar, 16'hFFFE);
    else passed++;
    m4_ = 1'b1;
    tick();
    pulse_load(16'h0001);
    p1 = 1'b1; m4_ = 1'b0;
    tick();
    total++;
    if (ar !== 16'hFFFE) $display("FAIL wrap_both: ar=%h expected %h", ar, 16'hFFFE);
    else passed++;
    p1 = 1'b0; m4_ = 1'b1;
    tick();
  endtask

  task automatic test_simultaneous();
    pulse_load(16'h1000);
    p1 = 1'b1; m4_ = 1'b0;
    tick();
    total++;
    if (ar !== 16'h0FFD) $display("FAIL inc_dec_same_edge: ar=%h expected %h", ar, 16'h0FFD);
    else passed++;
    p1 = 1'b0; m4_ = 1'b1;
    tick();
    w = 16'h1234; l_ = 1'b0; p1 = 1'b1; m4_ = 1'b0;
    tick();
    total++;
    if (ar !== 16'h1234) $display("FAIL load_priority: ar=%h expected %h", ar, 16'h1234);
    else passed++;
    l_ = 1'b1; p1 = 1'b0; m4_ = 1'b1;
    tick();
    total++;
    if (ar !== 16'h1234) $display("FAIL load_priority_release: ar=%h expected %h", ar, 16'h1234);
    else passed++;
  endtask

  task automatic test_reset_interaction();
    pulse_load(16'h0777);
    p1 = 1'b1;
    tick();
    total++;
    if (ar !== 16'h0778) $display("FAIL pre_reset_inc: ar=%h expected %h", ar, 16'h0778);
    else passed++;
    reset = 1'b1;
    tick();
    total++;
    if (ar !== 16'h0000) $display("FAIL mid_pulse_reset: ar=%h expected %h", ar, 16'h0000);
    else passed++;
    tick();
    reset = 1'b0;
    tick();
    total++;
    if (ar !== 16'h0001) $display("FAIL post_reset_event: ar=%h expected %h", ar, 16'h0001);
    else passed++;
    tick();
    total++;
    if (ar !== 16'h0001) $display("FAIL post_reset_single: ar=%h expected %h", ar, 16'h0001);
    else passed++;
    p1 = 1'b0;
    tick();
    p1 = 1'b1;
    tick();
    total++;
    if (ar !== 16'h0002) $display("FAIL new_edge_inc: ar=%h expected %h", ar, 16'h0002);
    else passed++;
    p1 = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    pulse_load(16'h2000);
    p1 = 1'b1;
    tick();
    p1 = 1'b0; m4_ = 1'b0;
    tick();
    total++;
    if (ar !== 16'h1FFD) $display("FAIL back_to_back: ar=%h expected %h", ar, 16'h1FFD);
    else passed++;
    m4_ = 1'b1; w = 16'hA5A5; l_ = 1'b0;
    tick();
    total++;
    if (ar !== 16'hA5A5) $display("FAIL back_to_back_load: ar=%h expected %h", ar, 16'hA5A5);
    else passed++;
    l_ = 1'b1;
    tick();
  endtask

  initial begin
    reset = 1'b1; w = 16'h0000; l_ = 1'b1; p1 = 1'b0; m4_ = 1'b1;
    #2;
    test_reset();
    test_load_inc_dec();
    test_long_strobes();
    test_wrap();
    test_simultaneous();
    test_reset_interaction();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
